// File: rtl/prog_sequencer_pkg.sv
// Shared types and instruction field positions for the program sequencer.
package prog_pkg;

    // Opcodes live in Instr[11:8]. ALU0..ALU9 are all plain register writes
    // here; the register file interprets the ALU function itself.
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MOV   = 4'd1,
        OP_LDI   = 4'd2,
        OP_SHL16 = 4'd3,
        OP_BGE   = 4'd4,
        OP_ALU0  = 4'd5,
        OP_ALU1  = 4'd6,
        OP_ALU2  = 4'd7,
        OP_ALU3  = 4'd8,
        OP_ALU4  = 4'd9,
        OP_ALU5  = 4'd10,
        OP_ALU6  = 4'd11,
        OP_ALU7  = 4'd12,
        OP_ALU8  = 4'd13,
        OP_ALU9  = 4'd14,
        OP_HALT  = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 8;
    localparam int RA_MSB   = 7;
    localparam int RA_LSB   = 4;
    localparam int RB_MSB   = 3;
    localparam int RB_LSB   = 0;
    localparam int FIELD_W  = 4;
    // Branch offset is the concatenation {ra, rb}, treated as signed.
    localparam int BR_OFF_W = 8;

    // MOV and every ALU opcode write ra with the result of (ra, rb).
    function automatic logic is_reg_write(input opcode_e op);
        return (op == OP_MOV) || ((op >= OP_ALU0) && (op <= OP_ALU9));
    endfunction

endpackage

// File: rtl/prog_sequencer_instr_decode.sv
// Splits a fetched instruction word into opcode, register fields and the
// branch offset. Purely combinational; no knowledge of sequencer state.
module instr_decode
    import prog_pkg::*;
#(
    parameter int IW = 12
)
(
    input  logic [IW-1:0]       i_instr,
    output opcode_e             o_op,
    output logic [FIELD_W-1:0]  o_ra,
    output logic [FIELD_W-1:0]  o_rb,
    output logic [BR_OFF_W-1:0] o_br_off,
    output logic                o_is_wr
);

    assign o_op     = opcode_e'(i_instr[OP_MSB:OP_LSB]);
    assign o_ra     = i_instr[RA_MSB:RA_LSB];
    assign o_rb     = i_instr[RB_MSB:RB_LSB];
    assign o_br_off = i_instr[RA_MSB:RB_LSB];
    assign o_is_wr  = is_reg_write(o_op);

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, fetches from the instruction ROM and
// drives register-file controls, including the two-word immediate load and
// the multi-cycle 16-bit shift.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | PC parked at 0, waiting for the falling edge of Start
//  ST_RUN   | decode word at PC, one instruction per cycle
//  ST_LOAD  | word at PC is LDI immediate data, presented on Imm
//  ST_SHIFT | one Shift strobe per cycle until the counter expires
//  ST_DONE  | HALT reached, Done held until Start is raised again
module prog_sequencer
    import prog_pkg::*;
#(
    parameter int W   = 8,
    parameter int D   = 4,
    parameter int IW  = 12,
    parameter int PCW = 10
)
(
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic [IW-1:0]  Instr,
    input  logic           GE_Flag,
    input  logic           IsLoadingReg,
    output logic [PCW-1:0] PC,
    output logic [D-1:0]   RaddrA,
    output logic [D-1:0]   RaddrB,
    output logic [D-1:0]   Waddr,
    output logic           WriteEn,
    output logic           RegSet,
    output logic           Shift,
    output logic           ImmSel,
    output logic [W-1:0]   Imm,
    output logic           Done,
    output logic           Err
);

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    logic [PCW-1:0]       r_pc;
    logic [PCW-1:0]       w_pc_nxt;
    logic [PCW-1:0]       w_pc_inc;
    logic [PCW-1:0]       w_br_tgt;
    logic [D-1:0]         r_cnt;
    logic [D-1:0]         w_cnt_nxt;
    logic                 r_done;
    logic                 r_err;
    logic                 w_err_set;
    logic                 r_start_q;

    opcode_e              w_op;
    logic [FIELD_W-1:0]   w_ra;
    logic [FIELD_W-1:0]   w_rb;
    logic [BR_OFF_W-1:0]  w_br_off;
    logic                 w_is_wr;

    instr_decode #(
        .IW (IW)
    ) u_decode (
        .i_instr  (Instr),
        .o_op     (w_op),
        .o_ra     (w_ra),
        .o_rb     (w_rb),
        .o_br_off (w_br_off),
        .o_is_wr  (w_is_wr)
    );

    // PC arithmetic wraps naturally at 2**PCW; the branch offset is sign
    // extended so backward branches past 0 land at the top of the ROM.
    assign w_pc_inc = r_pc + PCW'(1);
    assign w_br_tgt = r_pc + {{(PCW-BR_OFF_W){w_br_off[BR_OFF_W-1]}}, w_br_off};

    // Next-state, next-PC and register-file strobes. Start in any active
    // state aborts before any decode takes effect, so strobes stay low.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        RaddrA      = '0;
        RaddrB      = '0;
        Waddr       = '0;
        WriteEn     = 1'b0;
        RegSet      = 1'b0;
        Shift       = 1'b0;
        ImmSel      = 1'b0;
        Imm         = '0;

        case (r_state)
            ST_IDLE: begin
                w_pc_nxt  = '0;
                w_cnt_nxt = '0;
                // r_start_q is last cycle's Start: launch on its falling edge
                if (!Start && r_start_q) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (Start) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_pc_nxt = w_pc_inc;
                    case (w_op)
                        OP_NOP: begin
                        end
                        OP_LDI: begin
                            RegSet      = 1'b1;
                            RaddrB      = D'(w_rb);
                            w_state_nxt = ST_LOAD;
                        end
                        OP_SHL16: begin
                            // a zero count degenerates to a NOP
                            if (w_rb != '0) begin
                                w_state_nxt = ST_SHIFT;
                                w_cnt_nxt   = D'(w_rb);
                                w_pc_nxt    = r_pc;
                            end
                        end
                        OP_BGE: begin
                            if (GE_Flag) begin
                                w_pc_nxt = w_br_tgt;
                            end
                        end
                        OP_HALT: begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = ST_DONE;
                        end
                        default: begin
                            if (w_is_wr) begin
                                RaddrA  = D'(w_ra);
                                Waddr   = D'(w_ra);
                                RaddrB  = D'(w_rb);
                                WriteEn = 1'b1;
                            end
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                if (Start) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    ImmSel      = 1'b1;
                    Imm         = Instr[W-1:0];
                    // register file should be mid-load; flag it but keep going
                    w_err_set   = !IsLoadingReg;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_SHIFT: begin
                if (Start) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    Shift     = 1'b1;
                    w_cnt_nxt = r_cnt - D'(1);
                    if (r_cnt == D'(1)) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_DONE: begin
                if (Start) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, PC, shift counter and sticky flags; synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= (w_state_nxt == ST_DONE);
            r_err     <= r_err | w_err_set;
            r_start_q <= Start;
        end
    end

    assign PC   = r_pc;
    assign Done = r_done;
    assign Err  = r_err;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer. A program interpreter builds the
// expected per-cycle trace from the ROM contents, then the DUT is run and
// compared cycle by cycle, ending with a Start abort at a chosen cycle.
module tb_prog_sequencer;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int IW   = 12;
    localparam int PCW  = 10;
    localparam int MAXT = 100;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           Start;
    logic [IW-1:0]  Instr;
    logic           GE_Flag;
    logic           IsLoadingReg;
    logic [PCW-1:0] PC;
    logic [D-1:0]   RaddrA;
    logic [D-1:0]   RaddrB;
    logic [D-1:0]   Waddr;
    logic           WriteEn;
    logic           RegSet;
    logic           Shift;
    logic           ImmSel;
    logic [W-1:0]   Imm;
    logic           Done;
    logic           Err;

    logic [IW-1:0]  rom [0:1023];
    int             ge_tab [0:127];
    int             il_tab [0:127];
    logic [35:0]    exp_q [$];

    int n_err = 0;
    int n_chk = 0;

    prog_sequencer #(.W(W), .D(D), .IW(IW), .PCW(PCW)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Instr        (Instr),
        .GE_Flag      (GE_Flag),
        .IsLoadingReg (IsLoadingReg),
        .PC           (PC),
        .RaddrA       (RaddrA),
        .RaddrB       (RaddrB),
        .Waddr        (Waddr),
        .WriteEn      (WriteEn),
        .RegSet       (RegSet),
        .Shift        (Shift),
        .ImmSel       (ImmSel),
        .Imm          (Imm),
        .Done         (Done),
        .Err          (Err)
    );

    always #5 Clk = ~Clk;

    assign Instr = rom[PC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // {PC, RaddrA, RaddrB, Waddr, WriteEn, RegSet, Shift, ImmSel, Imm, Done, Err}
    function automatic logic [35:0] mk(input int pc, input int ra, input int rb, input int wa,
                                       input int we, input int rs, input int sh, input int is,
                                       input int imm, input int dn, input int er);
        return {10'(pc), 4'(ra), 4'(rb), 4'(wa), 1'(we), 1'(rs), 1'(sh), 1'(is),
                8'(imm), 1'(dn), 1'(er)};
    endfunction

    function automatic logic [35:0] obs_vec();
        return {PC, RaddrA, RaddrB, Waddr, WriteEn, RegSet, Shift, ImmSel, Imm, Done, Err};
    endfunction

    // Interpret the program: each instruction expands into the cycles it
    // occupies, with GE/IsLoadingReg taken from the per-cycle tables.
    task automatic build_trace();
        int          pc;
        int          err;
        int          op;
        int          ra;
        int          rb;
        int          idx;
        int          off;
        logic [11:0] ins;
        pc  = 0;
        err = 0;
        exp_q.delete();
        while (exp_q.size() < MAXT) begin
            ins = rom[pc];
            op  = int'(ins[11:8]);
            ra  = int'(ins[7:4]);
            rb  = int'(ins[3:0]);
            idx = exp_q.size();
            if (op == 15) begin
                exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, err));
                for (int k = 0; k < 3; k++)
                    exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 1, err));
                break;
            end else if (op == 0) begin
                exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, err));
                pc = pc + 1;
            end else if (op == 2) begin
                exp_q.push_back(mk(pc, 0, rb, 0, 0, 1, 0, 0, 0, 0, err));
                pc  = (pc + 1) % 1024;
                ins = rom[pc];
                idx = exp_q.size();
                exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 1, int'(ins[7:0]), 0, err));
                if (il_tab[idx] == 0) err = 1;
                pc = pc + 1;
            end else if (op == 3) begin
                exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, err));
                for (int k = 0; k < rb; k++)
                    exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 1, 0, 0, 0, err));
                pc = pc + 1;
            end else if (op == 4) begin
                exp_q.push_back(mk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, err));
                off = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
                pc  = (ge_tab[idx] != 0) ? pc + off : pc + 1;
            end else begin
                exp_q.push_back(mk(pc, ra, rb, ra, 1, 0, 0, 0, 0, 0, err));
                pc = pc + 1;
            end
            pc = ((pc % 1024) + 1024) % 1024;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) rom[i] = 12'h000;
        for (int i = 0; i < 128; i++) begin
            ge_tab[i] = 0;
            il_tab[i] = 1;
        end
    endtask

    // Reset with Start high; leaves the DUT idle with Start seen high,
    // positioned at a falling clock edge.
    task automatic do_reset();
        Reset_n      = 1'b0;
        Start        = 1'b1;
        GE_Flag      = 1'($urandom);
        IsLoadingReg = 1'($urandom);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset", 64'(obs_vec()), 64'd0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("idle_start_hi", 64'(obs_vec()), 64'd0);
    endtask

    // Run the current ROM from reset, compare the trace up to cycle abort_at
    // and abort there with Start=1 (abort_at<0: abort on the last traced cycle).
    task automatic run_prog(input string name, input int abort_at);
        int          a;
        logic [35:0] e;
        build_trace();
        a = (abort_at < 0 || abort_at >= exp_q.size()) ? exp_q.size() - 1 : abort_at;
        do_reset();
        Start = 1'b0;
        for (int t = 0; t < a; t++) begin
            @(posedge Clk);
            #1;
            GE_Flag      = (ge_tab[t] != 0);
            IsLoadingReg = (il_tab[t] != 0);
            @(negedge Clk);
            chk({name, "_trace"}, 64'(obs_vec()), 64'(exp_q[t]));
        end
        e = exp_q[a];
        @(posedge Clk);
        #1;
        Start        = 1'b1;
        GE_Flag      = (ge_tab[a] != 0);
        IsLoadingReg = (il_tab[a] != 0);
        @(negedge Clk);
        chk({name, "_abort"}, 64'(obs_vec()), 64'({e[35:26], 24'd0, e[1:0]}));
        @(posedge Clk);
        @(negedge Clk);
        chk({name, "_idle"}, 64'(obs_vec()), 64'({35'd0, e[0]}));
    endtask

    initial begin
        Reset_n      = 1'b0;
        Start        = 1'b1;
        GE_Flag      = 1'b0;
        IsLoadingReg = 1'b1;

        // reset while the ROM presents HALT at PC 0
        for (int i = 0; i < 1024; i++) rom[i] = 12'hF00;
        do_reset();

        // LDI rb=3, data 0x5A, HALT
        clear_prog();
        rom[0] = 12'h203;
        rom[1] = 12'h05A;
        rom[2] = 12'hF00;
        run_prog("ldi", -1);

        // same program, register file never acknowledges the load
        for (int i = 0; i < 128; i++) il_tab[i] = 0;
        run_prog("ldi_err", -1);

        // SHL16 n=4 at PC 5, SHL16 n=0 at PC 6, a MOV, then HALT
        clear_prog();
        rom[5] = 12'h304;
        rom[6] = 12'h300;
        rom[7] = 12'h1A7;
        rom[8] = 12'hF00;
        run_prog("shl", -1);

        // BGE 0xFE at PC 3: taken once (back to 1), then falls through to HALT
        clear_prog();
        rom[3] = 12'h4FE;
        rom[4] = 12'hF00;
        ge_tab[3] = 1;
        run_prog("bge", -1);

        // abort in the third shift cycle, counter at 2
        clear_prog();
        rom[0] = 12'h304;
        run_prog("shl_abort", 3);

        // branch -1 from PC 0 to the last ROM word, NOP there wraps to 0
        clear_prog();
        rom[0] = 12'h4FF;
        rom[1] = 12'hF00;
        ge_tab[0] = 1;
        run_prog("wrap", -1);

        // random programs, flags and abort points
        for (int r = 0; r < 25; r++) begin
            clear_prog();
            for (int i = 0; i < 64; i++) rom[i] = 12'($urandom);
            for (int i = 0; i < 128; i++) begin
                ge_tab[i] = int'($urandom_range(0, 1));
                il_tab[i] = ($urandom_range(0, 7) != 0) ? 1 : 0;
            end
            run_prog("rand", int'($urandom_range(0, 120)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
